// File: rtl/alu_controle_if.sv
// Request / ALU / result bundle between the ALU controller and its environment.
interface alu_controle_if #(parameter int LARGURA = 32);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         ALUOp;
  logic [5:0]         funct;
  logic [LARGURA-1:0] opA;
  logic [LARGURA-1:0] opB;
  logic [3:0]         ALUcontrol;
  logic [LARGURA-1:0] entradaA;
  logic [LARGURA-1:0] entradaB;
  logic [LARGURA-1:0] ALUsaida;
  logic               Zero;
  logic               out_valid;
  logic               out_ready;
  logic [LARGURA-1:0] resultado;
  logic               zero_out;
  logic               erro;

  modport slave (
    input  in_valid, ALUOp, funct, opA, opB, ALUsaida, Zero, out_ready,
    output in_ready, ALUcontrol, entradaA, entradaB, out_valid, resultado, zero_out, erro
  );

  modport master (
    output in_valid, ALUOp, funct, opA, opB, ALUsaida, Zero, out_ready,
    input  in_ready, ALUcontrol, entradaA, entradaB, out_valid, resultado, zero_out, erro
  );
endinterface

// File: rtl/alu_controle.sv
// ALU controller: accepts a request, drives an external ALU for one cycle, holds the result.
// Optional macro ALU_NOR_EN enables ALUOp=10 / funct=100111 as a legal NOR.
module alu_controle #(
  parameter int LARGURA = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_controle_if.slave bus
);
  typedef enum logic [1:0] {OCIOSO, EXECUTA, RESULTADO} estado_t;

  estado_t            r_state, w_next;
  logic               w_accept, w_capture;
  logic [3:0]         w_ctrl;
  logic               w_ilegal;
  logic [3:0]         r_ctrl;
  logic               r_ilegal;
  logic [LARGURA-1:0] r_a, r_b, r_res;
  logic               r_zero, r_erro;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= OCIOSO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      OCIOSO: if (bus.in_valid) begin
        w_next   = EXECUTA;
        w_accept = 1'b1;
      end
      EXECUTA: begin
        w_next    = RESULTADO;
        w_capture = 1'b1;
      end
      RESULTADO: if (bus.out_ready) w_next = OCIOSO;
      default: w_next = OCIOSO;
    endcase
  end

  // Unlisted ALUOp/funct combinations fall through to the 1111 error code.
  always_comb begin
    w_ctrl   = 4'b1111;
    w_ilegal = 1'b1;
    case (bus.ALUOp)
      2'b00: begin w_ctrl = 4'b0010; w_ilegal = 1'b0; end
      2'b01: begin w_ctrl = 4'b0110; w_ilegal = 1'b0; end
      2'b10: begin
        case (bus.funct)
          6'b100000: begin w_ctrl = 4'b0010; w_ilegal = 1'b0; end
          6'b100010: begin w_ctrl = 4'b0110; w_ilegal = 1'b0; end
          6'b100100: begin w_ctrl = 4'b0000; w_ilegal = 1'b0; end
          6'b100101: begin w_ctrl = 4'b0001; w_ilegal = 1'b0; end
          6'b101010: begin w_ctrl = 4'b0111; w_ilegal = 1'b0; end
`ifdef ALU_NOR_EN
          6'b100111: begin w_ctrl = 4'b1100; w_ilegal = 1'b0; end
`else
          6'b100111: begin w_ctrl = 4'b1111; w_ilegal = 1'b1; end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= 4'b0000;
      r_ilegal <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_zero   <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ctrl   <= w_ctrl;
        r_ilegal <= w_ilegal;
        r_a      <= bus.opA;
        r_b      <= bus.opB;
      end
      // Illegal requests ignore whatever the ALU produced for code 1111.
      if (w_capture) begin
        r_res  <= r_ilegal ? '0 : bus.ALUsaida;
        r_zero <= r_ilegal | bus.Zero;
        r_erro <= r_ilegal;
      end
    end
  end

  // Gating with reset keeps in_ready low while reset is held, even though state is OCIOSO.
  assign bus.in_ready   = (r_state == OCIOSO) && !reset;
  assign bus.out_valid  = (r_state == RESULTADO);
  assign bus.ALUcontrol = r_ctrl;
  assign bus.entradaA   = r_a;
  assign bus.entradaB   = r_b;
  assign bus.resultado  = r_res;
  assign bus.zero_out   = r_zero;
  assign bus.erro       = r_erro;
endmodule

// File: tb/tb_alu_controle.sv
// Bench for alu_controle: fixed vector table, reset corner cases, random requests vs a reference model.
module tb_alu_controle;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_controle_if #(.LARGURA(32)) bus();
  alu_controle #(.LARGURA(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  // External ALU stand-in; unknown codes produce a junk value the controller must mask.
  always_comb begin
    case (bus.ALUcontrol)
      4'b0010: bus.ALUsaida = bus.entradaA + bus.entradaB;
      4'b0110: bus.ALUsaida = bus.entradaA - bus.entradaB;
      4'b0000: bus.ALUsaida = bus.entradaA & bus.entradaB;
      4'b0001: bus.ALUsaida = bus.entradaA | bus.entradaB;
      4'b0111: bus.ALUsaida = {31'd0, $signed(bus.entradaA) < $signed(bus.entradaB)};
      4'b1100: bus.ALUsaida = ~(bus.entradaA | bus.entradaB);
      default: bus.ALUsaida = 32'hDEAD_BEEF;
    endcase
    bus.Zero = (bus.ALUcontrol == 4'b1111) ? 1'b0 : (bus.ALUsaida == 32'd0);
  end

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  code;
    logic [31:0] res;
    logic        z;
    logic        e;
    logic [2:0]  hold;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: operation chosen from the ALUOp/funct rules, result by plain arithmetic.
  task automatic ref_model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                           input logic [31:0] b, output logic [3:0] code, output logic [31:0] res,
                           output logic z, output logic e);
    string kind;
    kind = "bad";
    if (op == 2'd0) kind = "add";
    else if (op == 2'd1) kind = "sub";
    else if (op == 2'd2) begin
      if (fn == 6'h20) kind = "add";
      else if (fn == 6'h22) kind = "sub";
      else if (fn == 6'h24) kind = "and";
      else if (fn == 6'h25) kind = "or";
      else if (fn == 6'h2A) kind = "slt";
`ifdef ALU_NOR_EN
      else if (fn == 6'h27) kind = "nor";
`endif
    end
    e = 1'b0;
    case (kind)
      "add": begin code = 4'b0010; res = a + b; end
      "sub": begin code = 4'b0110; res = a - b; end
      "and": begin code = 4'b0000; res = a & b; end
      "or":  begin code = 4'b0001; res = a | b; end
      "slt": begin code = 4'b0111; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      "nor": begin code = 4'b1100; res = ~(a | b); end
      default: begin code = 4'b1111; res = 32'd0; e = 1'b1; end
    endcase
    z = (res == 32'd0);
  endtask

  task automatic run_req(input vec_t v);
    int t;
    @(negedge clk);
    t = 0;
    while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.ALUOp = v.op; bus.funct = v.fn; bus.opA = v.a; bus.opB = v.b;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.opA = ~v.a; bus.opB = ~v.b;
    chk("exec_ALUcontrol", {28'd0, bus.ALUcontrol}, {28'd0, v.code});
    chk("exec_entradaA", bus.entradaA, v.a);
    chk("exec_entradaB", bus.entradaB, v.b);
    chk("exec_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("exec_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("res_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("resultado", bus.resultado, v.res);
    chk("zero_out", {31'd0, bus.zero_out}, {31'd0, v.z});
    chk("erro", {31'd0, bus.erro}, {31'd0, v.e});
    for (int i = 0; i < int'(v.hold); i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("hold_resultado", bus.resultado, v.res);
      chk("hold_erro", {31'd0, bus.erro}, {31'd0, v.e});
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    chk("ret_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ret_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("ret_ALUcontrol_held", {28'd0, bus.ALUcontrol}, {28'd0, v.code});
    chk("ret_entradaA_held", bus.entradaA, v.a);
  endtask

  initial begin
    vec_t v;
    logic [5:0] fns[7];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00};

    tbl[0]  = '{2'b10, 6'b100000, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{2'b01, 6'b000000, 32'h1234, 32'h1234, 4'b0110, 32'd0, 1'b1, 1'b0, 3'd1};
    tbl[2]  = '{2'b10, 6'b101010, 32'd3, 32'd9, 4'b0111, 32'd1, 1'b0, 1'b0, 3'd4};
    tbl[3]  = '{2'b11, 6'b100000, 32'd5, 32'd7, 4'b1111, 32'd0, 1'b1, 1'b1, 3'd0};
`ifdef ALU_NOR_EN
    tbl[4]  = '{2'b10, 6'b100111, 32'd0, 32'd0, 4'b1100, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd0};
`else
    tbl[4]  = '{2'b10, 6'b100111, 32'd0, 32'd0, 4'b1111, 32'd0, 1'b1, 1'b1, 3'd0};
`endif
    tbl[5]  = '{2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 32'h0000_F000, 1'b0, 1'b0, 3'd0};
    tbl[6]  = '{2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_0F00, 4'b0001, 32'h0000_FFF0, 1'b0, 1'b0, 3'd2};
    tbl[7]  = '{2'b10, 6'b100010, 32'd3, 32'd5, 4'b0110, 32'hFFFF_FFFE, 1'b0, 1'b0, 3'd0};
    tbl[8]  = '{2'b00, 6'b111111, 32'd1, 32'hFFFF_FFFF, 4'b0010, 32'd0, 1'b1, 1'b0, 3'd0};
    tbl[9]  = '{2'b10, 6'b000000, 32'd8, 32'd8, 4'b1111, 32'd0, 1'b1, 1'b1, 3'd1};
    tbl[10] = '{2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0, 3'd0};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.ALUOp = 2'b00; bus.funct = 6'd0;
    bus.opA = 32'd0; bus.opB = 32'd0; bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_ALUcontrol", {28'd0, bus.ALUcontrol}, 32'd0);
    chk("rst_entradaA", bus.entradaA, 32'd0);
    chk("rst_resultado", bus.resultado, 32'd0);
    chk("rst_zero_erro", {30'd0, bus.zero_out, bus.erro}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1 chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 11; i++) run_req(tbl[i]);

    // Reset during EXECUTA: everything clears at once and the request is dropped.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.ALUOp = 2'b10; bus.funct = 6'b100000;
    bus.opA = 32'h0000_AAAA; bus.opB = 32'h0000_5555;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("mid_exec_ALUcontrol", {28'd0, bus.ALUcontrol}, 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ALUcontrol", {28'd0, bus.ALUcontrol}, 32'd0);
    chk("mid_rst_entradaA", bus.entradaA, 32'd0);
    chk("mid_rst_entradaB", bus.entradaB, 32'd0);
    chk("mid_rst_resultado", bus.resultado, 32'd0);
    chk("mid_rst_flags", {29'd0, bus.zero_out, bus.erro, bus.out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk); reset = 1'b0;
    #1 chk("mid_rst_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("dropped_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    run_req(tbl[0]);

    // Random requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      v.a  = $urandom;
      v.b  = ($urandom_range(0, 5) == 0) ? v.a : $urandom;
      v.hold = 3'($urandom_range(0, 2));
      ref_model(v.op, v.fn, v.a, v.b, v.code, v.res, v.z, v.e);
      run_req(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
